ahb_interconnect: RTL
=====================

AHB_INTERCONNECT -- requirements
Module: ahb_interconnect

Interface
REQ-001 The block SHALL expose parameter NUM_SLAVES, default 3, number of slave ports (1..8).
REQ-002 The block SHALL expose parameter ADDR_W, default 32, address width.
REQ-003 The block SHALL expose parameter DATA_W, default 32, data width.
REQ-004 The block SHALL expose parameter SEL_LSB, default 28, lowest address bit of the slave-select field.
REQ-005 The block SHALL expose parameter SEL_W, default 2, slave-select field width; 2^SEL_W >= NUM_SLAVES.
REQ-006 HCLK_i  in  1  single clock, all state on rising edge.
REQ-007 HRESETn_i  in  1  asynchronous, active-low reset.
REQ-008 HADDR_MASTER_bi  in  ADDR_W  master address-phase address.
REQ-009 HTRANS_MASTER_bi  in  2  transfer type; bit1=1 (NONSEQ/SEQ) marks an active transfer.
REQ-010 HWRITE_MASTER_i  in  1  address-phase write flag.
REQ-011 HWDATA_MASTER_bi  in  DATA_W  data-phase write data.
REQ-012 HRDATA_MASTER_bo  out  DATA_W  data-phase read data to master.
REQ-013 HREADY_MASTER_o  out  1  bus ready; low stalls the master.
REQ-014 HRESP_MASTER_o  out  1  0=OKAY, 1=ERROR.
REQ-015 HSEL_SLAVE_bo  out  NUM_SLAVES  one-hot address-phase select.
REQ-016 HADDR_SLAVE_bo / HTRANS_SLAVE_bo / HWRITE_SLAVE_o / HWDATA_SLAVE_bo  out  ADDR_W/2/1/DATA_W  broadcast copies of master signals.
REQ-017 HREADY_SLAVE_o  out  1  broadcast of HREADY_MASTER_o.
REQ-018 HRDATA_SLAVE_bi / HREADY_SLAVE_bi / HRESP_SLAVE_bi  in  NUM_SLAVES*DATA_W/NUM_SLAVES/NUM_SLAVES  flattened per-slave responses, slave k at slice k.
REQ-019 ERR_CNT_bo  out  8  saturating count of ERROR responses issued by the default slave.

Function
REQ-020 Decode: idx = HADDR_MASTER_bi[SEL_LSB+SEL_W-1:SEL_LSB]; idx < NUM_SLAVES maps to slave idx, otherwise to the internal default slave.
REQ-021 HSEL_SLAVE_bo[idx] SHALL be 1 combinationally only when HTRANS bit1=1 and idx < NUM_SLAVES; otherwise all zero.
REQ-022 Address, HTRANS, HWRITE and HWDATA SHALL be passed to all slaves combinationally, zero latency.
REQ-023 Data-phase registers dp_valid, dp_sel (SEL_W bits), dp_def SHALL load from the current address phase only on edges where HREADY_MASTER_o=1; they hold while HREADY_MASTER_o=0.
REQ-024 dp_valid=0: HREADY_MASTER_o=1, HRESP_MASTER_o=0, HRDATA_MASTER_bo=0.
REQ-025 dp_valid=1, dp_def=0: master HRDATA/HREADY/HRESP SHALL equal slave dp_sel's inputs combinationally.
REQ-026 Default slave FSM states DS_IDLE, DS_ERR1, DS_ERR2; DS_IDLE->DS_ERR1 when an unmapped active transfer is accepted (HREADY=1); DS_ERR1->DS_ERR2 unconditionally; DS_ERR2->DS_ERR1 if another unmapped active transfer is accepted that edge, else DS_IDLE.
REQ-027 DS_ERR1 SHALL drive HREADY=0, HRESP=1; DS_ERR2 SHALL drive HREADY=1, HRESP=1 (two-cycle AHB error); HRDATA=0 in both.
REQ-028 An unmapped address with HTRANS bit1=0 (IDLE/BUSY) SHALL get a zero-wait OKAY and not enter DS_ERR1.
REQ-029 ERR_CNT_bo SHALL increment by 1 on each DS_ERR1 entry and saturate at 255.
REQ-030 Back-to-back transfers to different slaves SHALL be supported with no idle cycle; address phase of transfer N+1 overlaps data phase of N.
REQ-031 A slave stalling (HREADY low) SHALL stall the master and freeze HSEL/address acceptance until it asserts HREADY.

Reset
REQ-032 While HRESETn_i=0: dp_valid=0, dp_sel=0, dp_def=0, FSM=DS_IDLE, ERR_CNT_bo=0; thus HREADY_MASTER_o=1, HRESP_MASTER_o=0, HRDATA_MASTER_bo=0.
REQ-033 Reset asserted mid-transfer (including DS_ERR1) SHALL abort immediately, asynchronously, to the REQ-032 values.

Verification
REQ-034 Read 0x0000_0010 (slave 0 returns 0xA5A5_0001, HREADY=1) -> HSEL=3'b001 in address cycle; HRDATA=0xA5A5_0001, HRESP=0 next cycle.
REQ-035 Write 0x1000_0004 then read 0x2000_0008 back-to-back -> HSEL 3'b010 then 3'b100 on consecutive cycles; HWDATA seen by slave 1 in cycle 2; slave 2 data returned in cycle 3.
REQ-036 Slave 1 holds HREADY low 3 cycles -> HREADY_MASTER_o low 3 cycles, next address held, HSEL unchanged until release.
REQ-037 Read 0x3000_0000 (unmapped, NONSEQ) -> cycle+1 HREADY=0/HRESP=1, cycle+2 HREADY=1/HRESP=1, ERR_CNT_bo=1; same address with HTRANS=IDLE -> OKAY, no count.
REQ-038 300 unmapped NONSEQ transfers -> ERR_CNT_bo saturates at 255; HRESETn_i pulsed low during DS_ERR1 -> outputs immediately HREADY=1, HRESP=0, ERR_CNT_bo=0.
REQ-039 Parameter sweep NUM_SLAVES=1 and 4 (SEL_W=2) -> decode and error behaviour consistent with REQ-020/026.

Source files
------------

// File: rtl/ahb_interconnect_if.sv
// AHB single-master interconnect bus bundle.
// The interconnect takes the "slave" modport: it responds to the master's address and data
// phases and fans them out to the downstream slaves.
// The "master" modport is the surrounding environment: it drives master requests and the
// per-slave responses.
interface ahb_interconnect_if #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
);
    // Master-facing signals
    logic [ADDR_W-1:0]            HADDR_MASTER_bi;
    logic [1:0]                   HTRANS_MASTER_bi;
    logic                         HWRITE_MASTER_i;
    logic [DATA_W-1:0]            HWDATA_MASTER_bi;
    logic [DATA_W-1:0]            HRDATA_MASTER_bo;
    logic                         HREADY_MASTER_o;
    logic                         HRESP_MASTER_o;

    // Slave-facing signals, slave k at slice k of each flattened vector
    logic [NUM_SLAVES-1:0]        HSEL_SLAVE_bo;
    logic [ADDR_W-1:0]            HADDR_SLAVE_bo;
    logic [1:0]                   HTRANS_SLAVE_bo;
    logic                         HWRITE_SLAVE_o;
    logic [DATA_W-1:0]            HWDATA_SLAVE_bo;
    logic                         HREADY_SLAVE_o;
    logic [NUM_SLAVES*DATA_W-1:0] HRDATA_SLAVE_bi;
    logic [NUM_SLAVES-1:0]        HREADY_SLAVE_bi;
    logic [NUM_SLAVES-1:0]        HRESP_SLAVE_bi;

    // Default-slave error statistics
    logic [7:0]                   ERR_CNT_bo;

    modport slave (
        input  HADDR_MASTER_bi, HTRANS_MASTER_bi, HWRITE_MASTER_i, HWDATA_MASTER_bi,
        output HRDATA_MASTER_bo, HREADY_MASTER_o, HRESP_MASTER_o,
        output HSEL_SLAVE_bo, HADDR_SLAVE_bo, HTRANS_SLAVE_bo, HWRITE_SLAVE_o,
        output HWDATA_SLAVE_bo, HREADY_SLAVE_o,
        input  HRDATA_SLAVE_bi, HREADY_SLAVE_bi, HRESP_SLAVE_bi,
        output ERR_CNT_bo
    );

    modport master (
        output HADDR_MASTER_bi, HTRANS_MASTER_bi, HWRITE_MASTER_i, HWDATA_MASTER_bi,
        input  HRDATA_MASTER_bo, HREADY_MASTER_o, HRESP_MASTER_o,
        input  HSEL_SLAVE_bo, HADDR_SLAVE_bo, HTRANS_SLAVE_bo, HWRITE_SLAVE_o,
        input  HWDATA_SLAVE_bo, HREADY_SLAVE_o,
        output HRDATA_SLAVE_bi, HREADY_SLAVE_bi, HRESP_SLAVE_bi,
        input  ERR_CNT_bo
    );
endinterface

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: address decode to NUM_SLAVES slaves, broadcast of the
// address/data phase, data-phase response mux, and an internal default slave that answers
// unmapped active transfers with a two-cycle ERROR and counts them (saturating at 255).
module ahb_interconnect #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_LSB    = 28,
    parameter int unsigned SEL_W      = 2
) (
    input logic               HCLK_i,
    input logic               HRESETn_i,
    ahb_interconnect_if.slave bus
);

    localparam int unsigned SelHi = SEL_LSB + SEL_W - 1;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    // Address-phase decode
    logic [SEL_W-1:0]      addr_idx;
    logic                  addr_active;
    logic                  addr_mapped;
    logic [NUM_SLAVES-1:0] hsel;

    // Data-phase tracking
    logic                  dp_valid;
    logic [SEL_W-1:0]      dp_sel;
    logic                  dp_def;

    // Default slave
    ds_state_e             ds_state;
    logic                  ds_hready;
    logic                  ds_hresp;
    logic [7:0]            err_cnt;
    logic                  err_start;

    // Master-side response
    logic                  hready_master;
    logic                  hresp_master;
    logic [DATA_W-1:0]     hrdata_master;

    assign addr_idx    = bus.HADDR_MASTER_bi[SelHi:SEL_LSB];
    assign addr_active = bus.HTRANS_MASTER_bi[1];
    assign addr_mapped = (32'(addr_idx) < NUM_SLAVES);

    // An unmapped NONSEQ/SEQ accepted on this edge starts a default-slave error
    assign err_start   = hready_master & addr_active & ~addr_mapped;

    // One-hot select for the addressed slave, only during an active transfer
    always_comb begin
        hsel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            hsel[k] = addr_active & (32'(addr_idx) == 32'(k));
        end
    end

    // Capture the address phase into the data phase whenever the bus is ready
    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            dp_valid <= 1'b0;
            dp_sel   <= '0;
            dp_def   <= 1'b0;
        end else if (hready_master) begin
            dp_valid <= addr_active;
            dp_sel   <= addr_idx;
            dp_def   <= ~addr_mapped;
        end
    end

    // Default slave: two-cycle ERROR response with registered HREADY/HRESP and error counter
    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            ds_state  <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            case (ds_state)
                DS_IDLE: begin
                    if (err_start) begin
                        ds_state  <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                DS_ERR1: begin
                    ds_state  <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= 1'b1;
                end
                DS_ERR2: begin
                    // Master may issue another unmapped transfer in the ERROR's second cycle
                    if (err_start) begin
                        ds_state  <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else begin
                        ds_state  <= DS_IDLE;
                        ds_hready <= 1'b1;
                        ds_hresp  <= 1'b0;
                    end
                end
                default: begin
                    ds_state  <= DS_IDLE;
                    ds_hready <= 1'b1;
                    ds_hresp  <= 1'b0;
                end
            endcase
        end
    end

    // Data-phase response mux: idle OKAY, selected slave, or default slave
    always_comb begin
        hready_master = 1'b1;
        hresp_master  = 1'b0;
        hrdata_master = '0;
        if (dp_valid) begin
            if (dp_def) begin
                hready_master = ds_hready;
                hresp_master  = ds_hresp;
            end else begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (32'(dp_sel) == 32'(k)) begin
                        hready_master = bus.HREADY_SLAVE_bi[k];
                        hresp_master  = bus.HRESP_SLAVE_bi[k];
                        hrdata_master = bus.HRDATA_SLAVE_bi[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    assign bus.HSEL_SLAVE_bo    = hsel;
    assign bus.HADDR_SLAVE_bo   = bus.HADDR_MASTER_bi;
    assign bus.HTRANS_SLAVE_bo  = bus.HTRANS_MASTER_bi;
    assign bus.HWRITE_SLAVE_o   = bus.HWRITE_MASTER_i;
    assign bus.HWDATA_SLAVE_bo  = bus.HWDATA_MASTER_bi;
    assign bus.HREADY_SLAVE_o   = hready_master;

    assign bus.HRDATA_MASTER_bo = hrdata_master;
    assign bus.HREADY_MASTER_o  = hready_master;
    assign bus.HRESP_MASTER_o   = hresp_master;
    assign bus.ERR_CNT_bo       = err_cnt;

endmodule
